// File: rtl/mux2_arb_pkg.sv
// Shared types and constants for the two-requester round-robin mux arbiter.
// The state encoding is fixed so that other blocks and debug tools can decode it.
package mux2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    GRANT0 = 2'b01,
    GRANT1 = 2'b10
  } arb_state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  // On a tie the requester that did not finish the previous packet wins.
  function automatic logic tie_winner(input logic rr_last);
    return (rr_last == REQ1) ? REQ0 : REQ1;
  endfunction

endpackage

// File: rtl/MUX_2X1_D.sv
// Single-bit 2:1 multiplexer: Y follows I1 when S is high, otherwise I0.
module MUX_2X1_D (
  input  logic I0,
  input  logic I1,
  input  logic S,
  output logic Y
);

  assign Y = S ? I1 : I0;

endmodule

// File: rtl/mux2_out_reg.sv
// One-entry valid/ready output register. It accepts a new beat whenever it is
// empty or its current beat drains in the same cycle.
module mux2_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  input  logic             y_ready,
  output logic             y_valid,
  output logic [WIDTH-1:0] y_data,
  output logic             y_last,
  output logic             space
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;
  logic             last_reg;

  assign space   = !valid_reg || y_ready;
  assign y_valid = valid_reg;
  assign y_data  = data_reg;
  assign y_last  = last_reg;

  // A load wins over a drain, so a beat arriving in the same cycle as the
  // previous one leaves keeps the stage full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
    end else if (load) begin
      valid_reg <= 1'b1;
      data_reg  <= load_data;
      last_reg  <= load_last;
    end else if (y_ready) begin
      valid_reg <= 1'b0;
    end
  end

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin, packet-locked arbiter that shares one 2:1 mux datapath between
// two streaming requesters and feeds a single registered output stage.
module mux2_rr_arbiter
  import mux2_arb_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             I0_valid,
  input  logic [WIDTH-1:0] I0_data,
  input  logic             I0_last,
  output logic             I0_ready,
  input  logic             I1_valid,
  input  logic [WIDTH-1:0] I1_data,
  input  logic             I1_last,
  output logic             I1_ready,
  output logic             Y_valid,
  output logic [WIDTH-1:0] Y_data,
  output logic             Y_last,
  input  logic             Y_ready,
  output logic             S,
  output logic             busy
);

  arb_state_t       state_reg;
  logic             rr_last_reg;
  logic             s_reg;
  logic             busy_reg;

  logic [WIDTH:0]   mux_in0;
  logic [WIDTH:0]   mux_in1;
  logic [WIDTH:0]   mux_out;
  logic             out_space;
  logic             accept;

  assign S    = s_reg;
  assign busy = busy_reg;

  // Data and last travel together through the mux; last sits in the top bit.
  assign mux_in0 = {I0_last, I0_data};
  assign mux_in1 = {I1_last, I1_data};

  generate
    for (genvar gi = 0; gi < WIDTH + 1; gi++) begin : gen_mux
      MUX_2X1_D u_mux (
        .I0 (mux_in0[gi]),
        .I1 (mux_in1[gi]),
        .S  (s_reg),
        .Y  (mux_out[gi])
      );
    end
  endgenerate

  // Ready depends only on grant state and output-stage room, never on valid.
  assign I0_ready = (state_reg == GRANT0) && out_space;
  assign I1_ready = (state_reg == GRANT1) && out_space;
  assign accept   = (I0_valid && I0_ready) || (I1_valid && I1_ready);

  mux2_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (accept),
    .load_data (mux_out[WIDTH-1:0]),
    .load_last (mux_out[WIDTH]),
    .y_ready   (Y_ready),
    .y_valid   (Y_valid),
    .y_data    (Y_data),
    .y_last    (Y_last),
    .space     (out_space)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      rr_last_reg <= REQ1;
      s_reg       <= REQ0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (I0_valid && (!I1_valid || tie_winner(rr_last_reg) == REQ0)) begin
            state_reg <= GRANT0;
            s_reg     <= REQ0;
            busy_reg  <= 1'b1;
          end else if (I1_valid) begin
            state_reg <= GRANT1;
            s_reg     <= REQ1;
            busy_reg  <= 1'b1;
          end
        end
        GRANT0: begin
          if (I0_valid && I0_ready && I0_last) begin
            state_reg   <= IDLE;
            rr_last_reg <= REQ0;
            busy_reg    <= 1'b0;
          end
        end
        GRANT1: begin
          if (I1_valid && I1_ready && I1_last) begin
            state_reg   <= IDLE;
            rr_last_reg <= REQ1;
            busy_reg    <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Producers must hold an offered beat until it is taken.
  a_i0_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (I0_valid && !I0_ready) ##1 I0_valid |-> ($stable(I0_data) && $stable(I0_last)));
  a_i1_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (I1_valid && !I1_ready) ##1 I1_valid |-> ($stable(I1_data) && $stable(I1_last)));

endmodule
